gf256_inverter: RTL and testbench

//   Multi-cycle GF(2^8) multiplicative inverse, y = x^-1 = x^254, for the RS(32,28) CD decoder.

---
 rtl/gf256_pkg.sv | 36 +++
 rtl/gf256_mult.sv | 15 +
 rtl/gf256_inverter.sv | 79 +++++++
 tb/tb_gf256_inverter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/gf256_pkg.sv
// rtl/gf256_pkg.sv - shared GF(2^8) constants, FSM states and field arithmetic helpers
package gf256_pkg;

    localparam int         GF_W      = 8;
    localparam logic [7:0] GF_POLY   = 8'h1D;
    localparam int         INV_STEPS = 6;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Shift-and-add product; the reduction folds bit 8 back in through the low polynomial bits.
    function automatic logic [GF_W-1:0] gf_mul(input logic [GF_W-1:0] a,
                                               input logic [GF_W-1:0] b,
                                               input logic [GF_W-1:0] poly);
        logic [GF_W-1:0] p;
        logic [GF_W-1:0] aa;
        p  = '0;
        aa = a;
        for (int i = 0; i < GF_W; i++) begin
            if (b[i]) begin
                p = p ^ aa;
            end
            aa = {aa[GF_W-2:0], 1'b0} ^ (aa[GF_W-1] ? poly : '0);
        end
        return p;
    endfunction

    function automatic logic [GF_W-1:0] gf_sq(input logic [GF_W-1:0] a,
                                              input logic [GF_W-1:0] poly);
        return gf_mul(a, a, poly);
    endfunction

endpackage

// File: rtl/gf256_mult.sv
// rtl/gf256_mult.sv - combinational GF(2^8) multiplier, X = A * B mod field polynomial
module gf256_mult
    import gf256_pkg::GF_W;
    import gf256_pkg::gf_mul;
#(
    parameter logic [GF_W-1:0] GF_POLY = gf256_pkg::GF_POLY
) (
    input  logic [GF_W-1:0] A,
    input  logic [GF_W-1:0] B,
    output logic [GF_W-1:0] X
);

    assign X = gf_mul(A, B, GF_POLY);

endmodule

// File: rtl/gf256_inverter.sv
// rtl/gf256_inverter.sv - multi-cycle GF(2^8) inverse y = x^254 by repeated square-and-multiply
module gf256_inverter
    import gf256_pkg::GF_W;
    import gf256_pkg::INV_STEPS;
    import gf256_pkg::state_t;
    import gf256_pkg::IDLE;
    import gf256_pkg::RUN;
    import gf256_pkg::DONE;
    import gf256_pkg::gf_sq;
#(
    parameter logic [GF_W-1:0] GF_POLY = gf256_pkg::GF_POLY
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic [GF_W-1:0] x,
    output logic [GF_W-1:0] y,
    output logic            o_ready
);

    state_t          state_q;
    logic [2:0]      step_q;
    logic [GF_W-1:0] xr_q;
    logic [GF_W-1:0] acc_q;
    logic [GF_W-1:0] y_q;
    logic            ready_q;

    logic [GF_W-1:0] acc_sq;
    logic [GF_W-1:0] acc_d;

    assign acc_sq = gf_sq(acc_q, GF_POLY);

    gf256_mult #(.GF_POLY(GF_POLY)) u_mult (
        .A (acc_sq),
        .B (xr_q),
        .X (acc_d)
    );

    // A new start wins over any state, so a restart silently drops the computation in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            step_q  <= '0;
            xr_q    <= '0;
            acc_q   <= '0;
            y_q     <= '0;
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            if (i_start) begin
                xr_q    <= x;
                acc_q   <= x;
                step_q  <= '0;
                state_q <= RUN;
            end else begin
                case (state_q)
                    RUN: begin
                        // acc walks x^3, x^7, ... x^127; the final square yields x^254.
                        if (step_q == 3'(INV_STEPS)) begin
                            acc_q   <= acc_sq;
                            y_q     <= acc_sq;
                            ready_q <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            acc_q  <= acc_d;
                            step_q <= step_q + 3'd1;
                        end
                    end
                    DONE:    state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign y       = y_q;
    assign o_ready = ready_q;

endmodule

// File: tb/tb_gf256_inverter.sv
// tb/tb_gf256_inverter.sv - scoreboard bench for gf256_inverter against a log/antilog field model
module tb_gf256_inverter;

    logic       i_clk   = 1'b0;
    logic       i_rst   = 1'b1;
    logic       i_start = 1'b0;
    logic [7:0] x       = 8'h00;
    logic [7:0] y;
    logic       o_ready;

    gf256_inverter dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (i_start),
        .x       (x),
        .y       (y),
        .o_ready (o_ready)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int xv;
        int exp_y;
        int due;
    } exp_t;

    exp_t sb[$];
    int   n_cmp    = 0;
    int   n_bad    = 0;
    int   cyc      = 0;
    int   last_y   = 0;
    bit   prev_rdy = 1'b0;
    int   exp_tab[256];
    int   log_tab[256];

    always @(posedge i_clk) cyc <= cyc + 1;

    function automatic int ref_mul(input int a, input int b);
        if (a == 0 || b == 0) return 0;
        return exp_tab[(log_tab[a] + log_tab[b]) % 255];
    endfunction

    function automatic int ref_inv(input int a);
        if (a == 0) return 0;
        return exp_tab[(255 - log_tab[a]) % 255];
    endfunction

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge i_clk) begin
        if (o_ready === 1'b1) begin
            check("single_cycle_pulse", int'(prev_rdy), 0);
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pulse: got o_ready=1 y=%0h, want no pulse (cycle %0d)", y, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("y_value", int'(y), e.exp_y);
                check("latency", cyc, e.due);
                if (e.xv != 0) check("x_times_y", ref_mul(e.xv, int'(y)), 1);
            end
            last_y = int'(y);
        end else begin
            check("y_hold", int'(y), last_y);
        end
        prev_rdy = (o_ready === 1'b1);
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic do_start(input int v);
        exp_t e;
        i_start = 1'b1;
        x       = v[7:0];
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        x       = 8'($urandom);
        e.xv    = v;
        e.exp_y = ref_inv(v);
        e.due   = cyc + 7;
        sb.delete();
        sb.push_back(e);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40 && sb.size() != 0; i++) idle(1);
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_done: got no o_ready within 40 cycles, want pulse");
            sb.delete();
        end
    endtask

    task automatic do_reset(input int n);
        i_rst = 1'b1;
        idle(1);
        last_y = 0;
        idle(n - 1);
        i_rst = 1'b0;
        sb.delete();
    endtask

    initial begin
        int e;
        e = 1;
        for (int i = 0; i < 255; i++) begin
            exp_tab[i] = e;
            log_tab[e] = i;
            e = e << 1;
            if ((e & 256) != 0) e = e ^ 285;
        end
        exp_tab[255] = 1;
        log_tab[0]   = 0;

        idle(3);
        last_y = 0;
        i_rst  = 1'b0;
        check("reset_y", int'(y), 0);
        check("reset_ready", int'(o_ready), 0);

        do_start(8'h01); wait_done(); check("inv_01", int'(y), 8'h01);
        do_start(8'h02); wait_done(); check("inv_02", int'(y), 8'h8E);
        do_start(8'h03); wait_done(); check("inv_03", int'(y), 8'hF4);
        do_start(8'h00); wait_done(); check("inv_00", int'(y), 8'h00);

        for (int v = 1; v < 256; v++) begin
            do_start(v);
            wait_done();
            idle(int'($urandom_range(0, 2)));
        end

        do_start(8'h02);
        idle(2);
        do_start(8'h03);
        wait_done();
        check("restart_y", int'(y), 8'hF4);

        do_start(8'h05);
        idle(3);
        do_reset(1);
        check("abort_y", int'(y), 0);
        check("abort_ready", int'(o_ready), 0);
        idle(12);
        do_start(8'h01); wait_done(); check("after_abort", int'(y), 8'h01);

        i_start = 1'b1;
        x       = 8'($urandom);
        do_reset(1);
        i_start = 1'b0;
        idle(12);
        check("start_rst_y", int'(y), 0);

        for (int k = 0; k < 10; k++) begin
            do_start(int'($urandom_range(0, 255)));
            idle(int'($urandom_range(0, 9)));
        end
        wait_done();

        do_start(int'($urandom_range(0, 255)));
        for (int k = 0; k < 20; k++) begin
            int i;
            for (i = 0; i < 20 && o_ready !== 1'b1; i++) idle(1);
            if (o_ready !== 1'b1) begin
                n_cmp++;
                n_bad++;
                $display("FAIL b2b_wait: got no o_ready within 20 cycles, want pulse");
            end
            do_start(int'($urandom_range(0, 255)));
        end
        wait_done();
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got simulation still running, want completion");
        $fatal(1, "watchdog");
    end

endmodule
